set_mode_sequencer: RTL and testbench

SET_MODE_SEQUENCER -- requirements
Module: set_mode_sequencer

---
 rtl/clock_ctrl_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 59 +++++
 rtl/set_mode_sequencer.sv | 113 +++++++++++
 tb/tb_set_mode_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared constants for the clock setting-mode sequencer: mode and field
// indices, default parameter values and a small wrap-around helper.
package clock_ctrl_pkg;

  localparam int DEF_N_SET_MODES     = 3;
  localparam int DEF_N_FIELDS        = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_TIMEOUT_TICKS   = 10;

  // Mode indices as presented on mode_idx; IDLE is always 0.
  typedef enum logic [2:0] {
    MODE_IDLE  = 3'd0,
    MODE_TIME  = 3'd1,
    MODE_DATE  = 3'd2,
    MODE_ALARM = 3'd3
  } mode_e;

  // Field indices within a setting mode.
  typedef enum logic [2:0] {
    FIELD_HH = 3'd0,
    FIELD_MM = 3'd1,
    FIELD_SS = 3'd2
  } field_e;

  // Increment v, returning to 0 after reaching last.
  function automatic logic [2:0] wrap_inc(input logic [2:0] v, input logic [2:0] last);
    return (v == last) ? 3'd0 : v + 3'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus level debouncer for one raw push button.
// Emits a single-cycle press pulse when a new pressed level is accepted;
// releases are accepted silently.
module btn_debounce
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  // Shift the raw input through the synchronizer and count consecutive
  // synchronized samples that disagree with the accepted level.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/set_mode_sequencer.sv
// Setting-mode sequencer for a clock: steps through IDLE and the setting
// modes on mode presses, selects the edited field on field presses and
// abandons a setting mode after TIMEOUT_TICKS seconds of inactivity.
module set_mode_sequencer
  import clock_ctrl_pkg::*;
#(
  parameter int N_SET_MODES     = DEF_N_SET_MODES,
  parameter int N_FIELDS        = DEF_N_FIELDS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_TICKS   = DEF_TIMEOUT_TICKS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode_btn,
  input  logic                   field_btn,
  input  logic                   adjust_act,
  input  logic                   tick_1hz,
  output logic [N_SET_MODES-1:0] set_en,
  output logic [2:0]             mode_idx,
  output logic [2:0]             field_sel,
  output logic                   commit_pulse,
  output logic                   abort_pulse
);

  localparam int            TW         = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [2:0]    MODE_LAST  = 3'(N_SET_MODES);
  localparam logic [2:0]    FIELD_LAST = 3'(N_FIELDS - 1);

  logic mode_press, field_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(mode_btn),
    .press  (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_field_db (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(field_btn),
    .press  (field_press)
  );

  logic [2:0]    mode_q, mode_d;
  logic [2:0]    field_q, field_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          commit_q, commit_d;
  logic          abort_q, abort_d;
  logic          in_set;

  // Next mode/field/inactivity state; a mode press outranks everything,
  // activity outranks a tick, and the timeout fires on the tick that
  // would make the count reach TIMEOUT_TICKS.
  always_comb begin
    mode_d     = mode_q;
    field_d    = field_q;
    idle_cnt_d = idle_cnt_q;
    commit_d   = 1'b0;
    abort_d    = 1'b0;
    in_set     = (mode_q != MODE_IDLE);
    if (mode_press) begin
      mode_d     = wrap_inc(mode_q, MODE_LAST);
      field_d    = FIELD_HH;
      idle_cnt_d = '0;
      commit_d   = in_set;
    end else if (in_set) begin
      if (field_press || adjust_act) begin
        idle_cnt_d = '0;
        if (field_press) field_d = wrap_inc(field_q, FIELD_LAST);
      end else if (tick_1hz) begin
        if (idle_cnt_q == TICK_LAST) begin
          mode_d     = MODE_IDLE;
          field_d    = FIELD_HH;
          idle_cnt_d = '0;
          abort_d    = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
    end
  end

  // Sequencer registers; reset returns to IDLE without any pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_IDLE;
      field_q    <= FIELD_HH;
      idle_cnt_q <= '0;
      commit_q   <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      field_q    <= field_d;
      idle_cnt_q <= idle_cnt_d;
      commit_q   <= commit_d;
      abort_q    <= abort_d;
    end
  end

  // One-hot decode of the active setting mode.
  always_comb begin
    set_en = '0;
    for (int k = 0; k < N_SET_MODES; k++) set_en[k] = (mode_q == 3'(k + 1));
  end

  assign mode_idx     = mode_q;
  assign field_sel    = field_q;
  assign commit_pulse = commit_q;
  assign abort_pulse  = abort_q;

endmodule

// File: tb/tb_set_mode_sequencer.sv
// Self-checking bench for set_mode_sequencer: directed scenarios with
// literal expectations plus randomized stimulus checked every cycle
// against a behavioural model of buttons, modes, fields and timeout.
module tb_set_mode_sequencer;

  localparam int NM = 3;
  localparam int NF = 3;
  localparam int D  = 4;
  localparam int T  = 3;

  logic          clk = 1'b0;
  logic          rst, mode_btn, field_btn, adjust_act, tick_1hz;
  logic [NM-1:0] set_en;
  logic [2:0]    mode_idx, field_sel;
  logic          commit_pulse, abort_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  set_mode_sequencer #(
    .N_SET_MODES(NM), .N_FIELDS(NF), .DEBOUNCE_CYCLES(D), .TIMEOUT_TICKS(T)
  ) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .field_btn(field_btn),
    .adjust_act(adjust_act), .tick_1hz(tick_1hz), .set_en(set_en),
    .mode_idx(mode_idx), .field_sel(field_sel),
    .commit_pulse(commit_pulse), .abort_pulse(abort_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Button path: raw level delayed by two clocks (zeroed by reset); a new
  // level is accepted once the last D delayed samples all disagree with the
  // accepted level; a pulse appears in the cycle after acceptance.
  int m_mode = 0, m_field = 0, m_idle = 0;
  bit m_commit = 0, m_abort = 0;
  bit m_press_vis[2];
  bit m_level[2];
  bit m_dly[2][2];
  bit m_win[2][$];

  initial begin
    bit raw[2];
    bit new_press[2];
    bit x, all_flip;
    forever begin
      @(posedge clk);
      raw[0] = mode_btn;
      raw[1] = field_btn;
      // sequencer reacts to pulses that were visible before this edge
      if (rst) begin
        m_mode = 0; m_field = 0; m_idle = 0; m_commit = 0; m_abort = 0;
      end else begin
        m_commit = 0;
        m_abort  = 0;
        if (m_press_vis[0]) begin
          m_commit = (m_mode != 0);
          m_mode   = (m_mode + 1) % (NM + 1);
          m_field  = 0;
          m_idle   = 0;
        end else if (m_mode != 0) begin
          if (m_press_vis[1] || adjust_act) begin
            m_idle = 0;
            if (m_press_vis[1]) m_field = (m_field + 1) % NF;
          end else if (tick_1hz) begin
            m_idle++;
            if (m_idle == T) begin
              m_mode = 0; m_field = 0; m_idle = 0; m_abort = 1;
            end
          end
        end
      end
      for (int b = 0; b < 2; b++) begin
        new_press[b] = 0;
        if (rst) begin
          m_dly[b][0] = 0; m_dly[b][1] = 0; m_level[b] = 0; m_win[b].delete();
        end else begin
          x = m_dly[b][1];
          m_dly[b][1] = m_dly[b][0];
          m_dly[b][0] = raw[b];
          m_win[b].push_back(x);
          if (m_win[b].size() > D) void'(m_win[b].pop_front());
          all_flip = (m_win[b].size() == D);
          for (int i = 0; i < m_win[b].size(); i++)
            if (m_win[b][i] == m_level[b]) all_flip = 0;
          if (all_flip) begin
            m_level[b]   = ~m_level[b];
            new_press[b] = m_level[b];
            m_win[b].delete();
          end
        end
        m_press_vis[b] = new_press[b];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_mode_idx", mode_idx, m_mode);
        check("cyc_set_en", set_en, (m_mode == 0) ? 0 : (1 << (m_mode - 1)));
        check("cyc_field_sel", field_sel, m_field);
        check("cyc_commit", commit_pulse, m_commit);
        check("cyc_abort", abort_pulse, m_abort);
        check("cyc_exclusive", commit_pulse & abort_pulse, 0);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_outs(input string tag, input int md, input int fs, input bit cm, input bit ab);
    check({tag, "_mode_idx"}, mode_idx, md);
    check({tag, "_set_en"}, set_en, (md == 0) ? 0 : (1 << (md - 1)));
    check({tag, "_field_sel"}, field_sel, fs);
    check({tag, "_commit"}, commit_pulse, cm);
    check({tag, "_abort"}, abort_pulse, ab);
    check({tag, "_model_mode"}, m_mode, md);
  endtask

  // Clean press: transition visible exactly D+3 cycles after the raw rise.
  task automatic press(input bit fld, input string tag, input int md, input int fs, input bit cm);
    if (fld) field_btn = 1'b1; else mode_btn = 1'b1;
    cyc(D + 2);
    check({tag, "_early_commit"}, commit_pulse, 0);
    cyc(1);
    expect_outs(tag, md, fs, cm, 0);
    cyc(1);
    check({tag, "_commit_one_cycle"}, commit_pulse, 0);
    if (fld) field_btn = 1'b0; else mode_btn = 1'b0;
    cyc(D + 4);
  endtask

  task automatic tick_pulse(input string tag, input int md, input int fs, input bit ab);
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    expect_outs(tag, md, fs, 0, ab);
    cyc(1);
    check({tag, "_abort_one_cycle"}, abort_pulse, 0);
    cyc(1);
  endtask

  int mh = 0, fh = 0;

  initial begin
    rst = 1'b1; mode_btn = 1'b0; field_btn = 1'b0; adjust_act = 1'b0; tick_1hz = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    expect_outs("reset", 0, 0, 0, 0);
    rst = 1'b0;
    cyc(2);

    // mode cycling
    press(0, "m1", 1, 0, 0);
    press(0, "m2", 2, 0, 1);
    press(0, "m3", 3, 0, 1);
    press(0, "m0", 0, 0, 1);

    // short glitch is rejected
    mode_btn = 1'b1; cyc(3); mode_btn = 1'b0;
    cyc(D + 6);
    expect_outs("glitch", 0, 0, 0, 0);

    // field stepping and clear on mode change
    press(0, "f_m1", 1, 0, 0);
    press(1, "f1", 1, 1, 0);
    press(1, "f2", 1, 2, 0);
    press(1, "f3", 1, 0, 0);
    press(1, "f4", 1, 1, 0);
    press(0, "f_m2", 2, 0, 1);

    // timeout in MODE2
    tick_pulse("t1", 2, 0, 0);
    tick_pulse("t2", 2, 0, 0);
    tick_pulse("t3", 0, 0, 1);

    // adjust activity restarts the count
    press(0, "a_m1", 1, 0, 0);
    tick_pulse("a1", 1, 0, 0);
    tick_pulse("a2", 1, 0, 0);
    adjust_act = 1'b1; cyc(1); adjust_act = 1'b0;
    tick_pulse("a3", 1, 0, 0);
    tick_pulse("a4", 1, 0, 0);
    tick_pulse("a5", 0, 0, 1);

    // mode press coincident with the timing-out tick
    press(0, "c_m1", 1, 0, 0);
    tick_pulse("c1", 1, 0, 0);
    tick_pulse("c2", 1, 0, 0);
    mode_btn = 1'b1;
    cyc(D + 2);
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    expect_outs("coinc", 2, 0, 1, 0);
    mode_btn = 1'b0;
    cyc(D + 4);

    // reset in MODE3 with field 2, then a button held through reset release
    press(0, "r_m3", 3, 0, 1);
    press(1, "r_f1", 3, 1, 0);
    press(1, "r_f2", 3, 2, 0);
    rst = 1'b1;
    cyc(1);
    expect_outs("rst_mid", 0, 0, 0, 0);
    mode_btn = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(D + 2);
    check("held_pre_mode_idx", mode_idx, 0);
    cyc(1);
    expect_outs("held", 1, 0, 0, 0);
    mode_btn = 1'b0;
    cyc(D + 4);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (mh == 0) begin
        mode_btn = $urandom_range(0, 1);
        mh = $urandom_range(1, 30);
      end else mh--;
      if (fh == 0) begin
        field_btn = $urandom_range(0, 1);
        fh = $urandom_range(1, 20);
      end else fh--;
      adjust_act = ($urandom_range(0, 15) == 0);
      tick_1hz   = ($urandom_range(0, 4) == 0);
      rst        = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    rst = 1'b0; mode_btn = 1'b0; field_btn = 1'b0; adjust_act = 1'b0; tick_1hz = 1'b0;
    cyc(3 * D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
